// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/gnt + rvalid handshake, and holds the word for the controller until
// the datapath signals advance. All outputs except the field slices are flops.
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            advance,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic [31:0]     retire_count
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state, next_state;
    logic            req_d;
    logic            take_adv;
    logic            take_data;
    logic [XLEN-1:0] sel_target;
    logic            sel_mis;

    // An advance only counts while a word is held; rvalid only while waiting.
    assign take_adv  = (state == S_HOLD) && advance;
    assign take_data = (state == S_WAIT) && imem_rvalid;

    // State register; reset abandons any in-flight fetch.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Next-state logic. gnt wins over a same-cycle rvalid in REQ since data
    // can only return after the grant.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: next_state = S_REQ;
            S_REQ:  if (imem_gnt)  next_state = S_WAIT;
            S_WAIT: if (imem_rvalid) next_state = S_HOLD;
            S_HOLD: if (advance)   next_state = S_REQ;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode: request is asserted for the whole time we sit in REQ.
    always_comb begin
        req_d = (next_state == S_REQ);
    end

    // Next-PC select; reserved encoding falls back to sequential fetch.
    // Targets are word-aligned by dropping the low bits, flagging if they were set.
    always_comb begin
        sel_target = pc + FOUR;
        sel_mis    = 1'b0;
        case (pc_src)
            2'b01: begin
                sel_target = {branch_target[XLEN-1:2], 2'b00};
                sel_mis    = |branch_target[1:0];
            end
            2'b10: begin
                sel_target = {jalr_target[XLEN-1:2], 2'b00};
                sel_mis    = |jalr_target[1:0];
            end
            default: ;
        endcase
    end

    // Registered fetch datapath: PC, held word, retire counter, misalign pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            pc           <= RESET_PC;
            pc_plus4     <= RESET_PC + FOUR;
            instr_valid  <= 1'b0;
            instr        <= NOP_INSTR;
            misaligned   <= 1'b0;
            retire_count <= 32'd0;
        end else begin
            imem_req   <= req_d;
            misaligned <= 1'b0;
            if (take_data) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (take_adv) begin
                pc           <= sel_target;
                pc_plus4     <= sel_target + FOUR;
                imem_addr    <= sel_target;
                instr_valid  <= 1'b0;
                instr        <= NOP_INSTR;
                retire_count <= retire_count + 32'd1;
                misaligned   <= sel_mis;
            end
        end
    end

    // Field views of the held word; the NOP value supplies them when empty.
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, fetch handshake, PC select,
// misalignment, stalled handshakes, reset mid-fetch and PC wrap.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_src;
    logic [31:0] branch_target, jalr_target;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc, pc_plus4;
    logic        misaligned;
    logic [31:0] retire_count;

    int vectors = 0;
    int miscompares = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .branch_target(branch_target),
        .jalr_target(jalr_target), .advance(advance), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .pc(pc),
        .pc_plus4(pc_plus4), .misaligned(misaligned), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge (drive and sample point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From REQ: grant now, data the next cycle, leaving the unit in HOLD.
    task automatic fetch(input logic [31:0] word);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; pc_src = 2'b00; branch_target = '0; jalr_target = '0;
        advance = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        tick(); tick();
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %0h want 0", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0h want 0", instr_valid); end
        vectors++; if (instr !== 32'h13) begin miscompares++; $display("FAIL reset_instr got %h want 00000013", instr); end
        vectors++; if (opcode !== 7'h13) begin miscompares++; $display("FAIL reset_opcode got %h want 13", opcode); end
        vectors++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL reset_pc got %h/%h want 0/4", pc, pc_plus4); end
        vectors++; if (misaligned !== 1'b0 || retire_count !== 32'd0) begin miscompares++; $display("FAIL reset_misc got %0h/%0d want 0/0", misaligned, retire_count); end
    endtask

    task automatic test_basic_fetch();
        rst = 1'b1;
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL fetch_req got %0h/%h want 1/0", imem_req, imem_addr); end
        // rvalid together with gnt in REQ must be ignored
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_wait got req %0h valid %0h want 0/0", imem_req, instr_valid); end
        imem_gnt = 1'b0; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093) begin miscompares++; $display("FAIL fetch_hold got %0h/%h want 1/00500093", instr_valid, instr); end
        vectors++; if (opcode !== 7'h13 || funct3 !== 3'h0 || funct7 !== 7'h0) begin miscompares++; $display("FAIL fetch_fields got %h/%h/%h want 13/0/0", opcode, funct3, funct7); end
        vectors++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL fetch_pc got %h/%h want 0/4", pc, pc_plus4); end
        tick();
        vectors++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL hold_stable got %0h/%0h want 1/0", instr_valid, imem_req); end
    endtask

    task automatic test_branch();
        advance = 1'b1; pc_src = 2'b01; branch_target = 32'h40;
        tick();
        advance = 1'b0; pc_src = 2'b00;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin miscompares++; $display("FAIL branch_addr got %0h/%h want 1/40", imem_req, imem_addr); end
        vectors++; if (retire_count !== 32'd1 || misaligned !== 1'b0) begin miscompares++; $display("FAIL branch_count got %0d/%0h want 1/0", retire_count, misaligned); end
        vectors++; if (instr_valid !== 1'b0 || instr !== 32'h13) begin miscompares++; $display("FAIL branch_clear got %0h/%h want 0/00000013", instr_valid, instr); end
        vectors++; if (pc !== 32'h40 || pc_plus4 !== 32'h44) begin miscompares++; $display("FAIL branch_pc got %h/%h want 40/44", pc, pc_plus4); end
        fetch(32'h4000_0033);
        vectors++; if (funct7 !== 7'h20 || opcode !== 7'h33) begin miscompares++; $display("FAIL branch_fields got %h/%h want 20/33", funct7, opcode); end
    endtask

    task automatic test_jalr_misaligned();
        advance = 1'b1; pc_src = 2'b10; jalr_target = 32'h103;
        tick();
        advance = 1'b0; pc_src = 2'b00;
        vectors++; if (imem_addr !== 32'h100 || pc !== 32'h100) begin miscompares++; $display("FAIL jalr_addr got %h/%h want 100/100", imem_addr, pc); end
        vectors++; if (misaligned !== 1'b1 || retire_count !== 32'd2) begin miscompares++; $display("FAIL jalr_mis got %0h/%0d want 1/2", misaligned, retire_count); end
        tick();
        vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL jalr_pulse got %0h want 0", misaligned); end
    endtask

    task automatic test_stalled_handshake();
        // Unit is in REQ at 0x100 with no grant so far; stray rvalid must be ignored.
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = (i == 1); imem_rdata = 32'hFFFF_FFFF;
            tick();
            vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL stall_req%0d got %0h/%h/%0h want 1/100/0", i, imem_req, imem_addr, instr_valid); end
        end
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        advance = 1'b1; pc_src = 2'b01; branch_target = 32'h200;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (instr_valid !== 1'b0 || pc !== 32'h100 || retire_count !== 32'd2 || imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_wait%0d got %0h/%h/%0d/%0h want 0/100/2/0", i, instr_valid, pc, retire_count, imem_req); end
        end
        advance = 1'b0; pc_src = 2'b00;
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'h0010_0113 || pc !== 32'h100) begin miscompares++; $display("FAIL stall_hold got %0h/%h/%h want 1/00100113/100", instr_valid, instr, pc); end
    endtask

    task automatic test_reset_in_wait();
        advance = 1'b1;
        tick();
        advance = 1'b0;
        vectors++; if (imem_addr !== 32'h104 || retire_count !== 32'd3) begin miscompares++; $display("FAIL seq_addr got %h/%0d want 104/3", imem_addr, retire_count); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b0;
        tick();
        vectors++; if (imem_req !== 1'b0 || pc !== 32'h0 || retire_count !== 32'd0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rstwait got %0h/%h/%0d/%0h want 0/0/0/0", imem_req, pc, retire_count, instr_valid); end
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (instr_valid !== 1'b0 || instr !== 32'h13 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL late_rvalid got %0h/%h/%0h/%h want 0/00000013/1/0", instr_valid, instr, imem_req, imem_addr); end
        fetch(32'h0000_0013);
        vectors++; if (instr_valid !== 1'b1 || pc !== 32'h0) begin miscompares++; $display("FAIL refetch got %0h/%h want 1/0", instr_valid, pc); end
    endtask

    task automatic test_wrap();
        advance = 1'b1; pc_src = 2'b01; branch_target = 32'hFFFF_FFFC;
        tick();
        advance = 1'b0; pc_src = 2'b00;
        vectors++; if (pc_plus4 !== 32'h0 || imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_p4 got %h/%h want 0/fffffffc", pc_plus4, imem_addr); end
        fetch(32'h0000_0013);
        advance = 1'b1; pc_src = 2'b00;
        tick();
        advance = 1'b0;
        vectors++; if (imem_addr !== 32'h0 || pc !== 32'h0 || retire_count !== 32'd2) begin miscompares++; $display("FAIL wrap_pc got %h/%h/%0d want 0/0/2", imem_addr, pc, retire_count); end
        fetch(32'h0000_0013);
        advance = 1'b1; pc_src = 2'b11; branch_target = 32'h80; jalr_target = 32'h90;
        tick();
        advance = 1'b0; pc_src = 2'b00;
        vectors++; if (imem_addr !== 32'h4 || misaligned !== 1'b0 || retire_count !== 32'd3) begin miscompares++; $display("FAIL src11 got %h/%0h/%0d want 4/0/3", imem_addr, misaligned, retire_count); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_branch();
        test_jalr_misaligned();
        test_stalled_handshake();
        test_reset_in_wait();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
